// File: rtl/pipelined_cla_pkg.sv
// Shared constants, operation encoding and look-ahead helpers for the pipelined CLA adder.
package pipelined_cla_pkg;

  localparam int unsigned WIDTH_DEF            = 32;
  localparam int unsigned GROUP_DEF            = 4;
  localparam int unsigned GROUPS_PER_STAGE_DEF = 2;

  // Widest generate/propagate chain the look-ahead helper accepts.
  localparam int unsigned LA_MAX = 64;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  function automatic int unsigned stages_f(input int unsigned width, input int unsigned group,
                                           input int unsigned gps);
    return width / (group * gps);
  endfunction

  // Carry into position n of a p/g chain as a flat sum of products:
  // ci&p[0..n-1] | g[0]&p[1..n-1] | ... | g[n-1].
  function automatic logic la_carry(input logic [LA_MAX-1:0] p, input logic [LA_MAX-1:0] g,
                                    input logic ci, input int unsigned n);
    logic c;
    logic term;
    term = ci;
    for (int unsigned m = 0; m < n; m++) begin
      term = term & p[m[5:0]];
    end
    c = term;
    for (int unsigned j = 0; j < n; j++) begin
      term = g[j[5:0]];
      for (int unsigned m = j + 1; m < n; m++) begin
        term = term & p[m[5:0]];
      end
      c = c | term;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// One combinational look-ahead group: per-bit carries, sum, and group propagate/generate.
module cla_group
  import pipelined_cla_pkg::*;
#(
  parameter int unsigned GROUP = GROUP_DEF
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             ci_i,
  output logic [GROUP-1:0] s_o,
  output logic             p_o,
  output logic             g_o,
  output logic [GROUP-1:0] c_o
);

  logic [LA_MAX-1:0] pv;
  logic [LA_MAX-1:0] gv;

  // Every carry is computed directly from ci and the bit p/g terms, never rippled.
  always_comb begin
    pv             = '0;
    gv             = '0;
    pv[GROUP-1:0]  = a_i ^ b_i;
    gv[GROUP-1:0]  = a_i & b_i;
    c_o            = '0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      c_o[i] = la_carry(pv, gv, ci_i, i);
    end
    s_o = pv[GROUP-1:0] ^ c_o;
    p_o = &pv[GROUP-1:0];
    g_o = la_carry(pv, gv, 1'b0, GROUP);
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor with a single global advance enable.
// Level 0 captures the (possibly inverted) operands; stage k resolves slice k between
// level k and level k+1, so the result is at level STAGES.
module pipelined_cla_adder
  import pipelined_cla_pkg::*;
#(
  parameter int unsigned WIDTH            = WIDTH_DEF,
  parameter int unsigned GROUP            = GROUP_DEF,
  parameter int unsigned GROUPS_PER_STAGE = GROUPS_PER_STAGE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned S          = GROUP * GROUPS_PER_STAGE;
  localparam int unsigned STAGES     = stages_f(WIDTH, GROUP, GROUPS_PER_STAGE);
  localparam int unsigned NUM_GROUPS = WIDTH / GROUP;

  logic             valid_q [0:STAGES];
  logic             valid_d [0:STAGES];
  logic             carry_q [0:STAGES];
  logic             carry_d [0:STAGES];
  logic [WIDTH-1:0] sum_q   [0:STAGES];
  logic [WIDTH-1:0] sum_d   [0:STAGES];
  logic [WIDTH-1:0] opa_q   [0:STAGES-1];
  logic [WIDTH-1:0] opa_d   [0:STAGES-1];
  logic [WIDTH-1:0] opb_q   [0:STAGES-1];
  logic [WIDTH-1:0] opb_d   [0:STAGES-1];
  logic             ovf_q;
  logic             ovf_d;

  logic [WIDTH-1:0]      grp_s;
  logic [WIDTH-1:0]      grp_c;
  logic [NUM_GROUPS-1:0] grp_p;
  logic [NUM_GROUPS-1:0] grp_g;
  logic [NUM_GROUPS-1:0] grp_ci;
  logic [STAGES-1:0]     stage_co;
  logic                  adv;
  op_t                   op;

  assign op          = op_t'(sub_i);
  assign adv         = ~valid_q[STAGES] | out_ready_i;
  assign in_ready_o  = adv;
  assign out_valid_o = valid_q[STAGES];
  assign sum_o       = sum_q[STAGES];
  assign cout_o      = carry_q[STAGES];
  assign ovf_o       = ovf_q;

  // Only the carry into the MSB is needed outside the groups (for overflow).
  logic unused_carries;
  assign unused_carries = ^grp_c[WIDTH-2:0];

  for (genvar n = 0; n < NUM_GROUPS; n++) begin : g_grp
    localparam int unsigned K = n / GROUPS_PER_STAGE;
    cla_group #(
      .GROUP(GROUP)
    ) u_grp (
      .a_i (opa_q[K][n*GROUP +: GROUP]),
      .b_i (opb_q[K][n*GROUP +: GROUP]),
      .ci_i(grp_ci[n]),
      .s_o (grp_s[n*GROUP +: GROUP]),
      .p_o (grp_p[n]),
      .g_o (grp_g[n]),
      .c_o (grp_c[n*GROUP +: GROUP])
    );
  end

  // Second look-ahead level: group carries and stage carry-out from group P/G.
  always_comb begin
    logic [LA_MAX-1:0] pv;
    logic [LA_MAX-1:0] gv;
    grp_ci   = '0;
    stage_co = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      pv = '0;
      gv = '0;
      for (int unsigned m = 0; m < GROUPS_PER_STAGE; m++) begin
        pv[m] = grp_p[k*GROUPS_PER_STAGE + m];
        gv[m] = grp_g[k*GROUPS_PER_STAGE + m];
      end
      for (int unsigned l = 0; l < GROUPS_PER_STAGE; l++) begin
        grp_ci[k*GROUPS_PER_STAGE + l] = la_carry(pv, gv, carry_q[k], l);
      end
      stage_co[k] = la_carry(pv, gv, carry_q[k], GROUPS_PER_STAGE);
    end
  end

  // Next-level contents: capture at level 0, one resolved slice per later level.
  always_comb begin
    valid_d[0] = in_valid_i;
    opa_d[0]   = a_i;
    opb_d[0]   = (op == OP_SUB) ? ~b_i : b_i;
    carry_d[0] = (op == OP_SUB) ? ~cin_i : cin_i;
    sum_d[0]   = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      opa_d[k] = opa_q[k-1];
      opb_d[k] = opb_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      valid_d[k+1]            = valid_q[k];
      carry_d[k+1]            = stage_co[k];
      sum_d[k+1]              = sum_q[k];
      sum_d[k+1][k*S +: S]    = grp_s[k*S +: S];
    end
    ovf_d = stage_co[STAGES-1] ^ grp_c[WIDTH-1];
  end

  // Pipeline registers: all levels advance together or all hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k <= STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k <= STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        sum_q[k]   <= sum_d[k];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule
